pc_stack_sequencer: RTL

- Owns the program counter and the 8-level hardware call/return stack for the PIC16F core.
- Executes one-cycle PC-update strobes from the instruction decoder: increment, GOTO, CALL, RETURN/RETLW, and computed write to PCL.
- Applies PCLATH paging to the jump target and drives the instruction fetch address.
- Sits between the instruction decoder and the program memory address port.

---
 rtl/pc_stack_sequencer_if.sv | 44 ++++
 rtl/pc_stack_sequencer.sv | 98 +++++++++
 2 files changed

// File: rtl/pc_stack_sequencer_if.sv
// Decoder-to-sequencer strobes plus the fetch address/stack depth returned to the decoder.
// Combinational bundle only (no latency). No backpressure; status pins exist only with PC_STACK_STATUS_EN.
// The master side is the instruction decoder; the slave side is pc_stack_sequencer.
interface pc_stack_sequencer_if #(
    parameter int PC_WIDTH = 13
);
    logic                pc_incr_en;
    logic                pc_j_en;
    logic                pc_call_en;
    logic                pc_ret_en;
    logic                pcl_wr_en;
    logic [7:0]          pcl_wr_data;
    logic [4:0]          pclath;
    logic [10:0]         j_addr;
    logic [PC_WIDTH-1:0] pc;
    logic [3:0]          stack_depth;
`ifdef PC_STACK_STATUS_EN
    logic                stack_flag_clr;
    logic                stack_ovf;
    logic                stack_unf;

    modport master (
        output pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, pcl_wr_en,
        output pcl_wr_data, pclath, j_addr, stack_flag_clr,
        input  pc, stack_depth, stack_ovf, stack_unf
    );
    modport slave (
        input  pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, pcl_wr_en,
        input  pcl_wr_data, pclath, j_addr, stack_flag_clr,
        output pc, stack_depth, stack_ovf, stack_unf
    );
`else
    modport master (
        output pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, pcl_wr_en,
        output pcl_wr_data, pclath, j_addr,
        input  pc, stack_depth
    );
    modport slave (
        input  pc_incr_en, pc_j_en, pc_call_en, pc_ret_en, pcl_wr_en,
        input  pcl_wr_data, pclath, j_addr,
        output pc, stack_depth
    );
`endif
endinterface

// File: rtl/pc_stack_sequencer.sv
// PIC16F program counter with 8-level circular call/return stack; PC_STACK_STATUS_EN adds sticky ovf/unf flags.
// Latency: a strobe sampled at edge N shows its new pc right after edge N.
// Backpressure: none; strobes are single-cycle pulses, priority ret > call > j > pcl_wr > incr.
module pc_stack_sequencer #(
    parameter int                  PC_WIDTH     = 13,
    parameter int                  STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = 13'h0000
) (
    input logic                 clk,
    input logic                 rst,
    pc_stack_sequencer_if.slave bus
);
    localparam int         SPW       = $clog2(STACK_DEPTH);
    localparam logic [3:0] DEPTH_MAX = 4'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [PC_WIDTH-1:0] pc_inc, j_target, pcl_target;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];
    logic [SPW-1:0]      sp_q, sp_d, sp_m1;
    logic [3:0]          depth_q, depth_d;
    logic                ret_win, call_win, push;

    assign pc_inc     = pc_q + PC_WIDTH'(1);
    assign j_target   = PC_WIDTH'({bus.pclath[4:3], bus.j_addr});
    assign pcl_target = PC_WIDTH'({bus.pclath, bus.pcl_wr_data});
    assign sp_m1      = sp_q - SPW'(1);
    assign ret_win    = bus.pc_ret_en;
    assign call_win   = bus.pc_call_en & ~bus.pc_ret_en;

    always_comb begin
        pc_d    = pc_q;
        sp_d    = sp_q;
        depth_d = depth_q;
        push    = 1'b0;
        if (ret_win) begin
            // An empty stack still pops circularly; only the depth count saturates.
            sp_d    = sp_m1;
            pc_d    = stack_q[sp_m1];
            depth_d = (depth_q == 4'd0) ? 4'd0 : depth_q - 4'd1;
        end else if (call_win) begin
            push    = 1'b1;
            sp_d    = sp_q + SPW'(1);
            pc_d    = j_target;
            depth_d = (depth_q == DEPTH_MAX) ? DEPTH_MAX : depth_q + 4'd1;
        end else if (bus.pc_j_en) begin
            pc_d = j_target;
        end else if (bus.pcl_wr_en) begin
            pc_d = pcl_target;
        end else if (bus.pc_incr_en) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_VECTOR;
            sp_q    <= '0;
            depth_q <= 4'd0;
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            depth_q <= depth_d;
            // A full stack overwrites its oldest slot, matching PIC behaviour.
            if (push) begin
                stack_q[sp_q] <= pc_inc;
            end
        end
    end

    assign bus.pc          = pc_q;
    assign bus.stack_depth = depth_q;

`ifdef PC_STACK_STATUS_EN
    logic ovf_q, unf_q, ovf_set, unf_set;

    assign ovf_set = call_win & (depth_q == DEPTH_MAX);
    assign unf_set = ret_win & (depth_q == 4'd0);

    // Set beats a coincident clear so an event in the clearing cycle is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (ovf_set)                 ovf_q <= 1'b1;
            else if (bus.stack_flag_clr) ovf_q <= 1'b0;
            if (unf_set)                 unf_q <= 1'b1;
            else if (bus.stack_flag_clr) unf_q <= 1'b0;
        end
    end

    assign bus.stack_ovf = ovf_q;
    assign bus.stack_unf = unf_q;
`endif
endmodule
